// File: rtl/fmul_share_ctrl_if.sv
// rtl/fmul_share_ctrl_if.sv - requester, multiplier and response signal bundle for fmul_share_ctrl
//
// Purpose: groups everything between the sharing controller and its
// neighbours. The master modport is the controller's view; the slave
// modport is the view of the surrounding system (requesters, the shared
// multiplier and the response consumer).
//
// Signals:
//   req          requester request levels, one bit per requester
//   a_bus/b_bus  packed operands, requester k at [32k+31:32k]
//   gnt          one-hot one-cycle grant pulse
//   busy         controller not idle
//   mul_A/mul_B  operands held for the multiplier
//   mul_start    multiplier start level
//   mul_result   multiplier product
//   mul_done_sig multiplier {over,under,zero,done}
//   resp_*       tagged one-cycle response

interface fmul_share_ctrl_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] a_bus;
    logic [32*NUM_REQ-1:0] b_bus;
    logic [NUM_REQ-1:0]    gnt;
    logic                  busy;
    logic [31:0]           mul_A;
    logic [31:0]           mul_B;
    logic                  mul_start;
    logic [31:0]           mul_result;
    logic [3:0]            mul_done_sig;
    logic                  resp_valid;
    logic [ID_W-1:0]       resp_id;
    logic [31:0]           resp_result;
    logic [2:0]            resp_flags;

    modport master (
        input  req, a_bus, b_bus, mul_result, mul_done_sig,
        output gnt, busy, mul_A, mul_B, mul_start,
               resp_valid, resp_id, resp_result, resp_flags
    );

    modport slave (
        output req, a_bus, b_bus, mul_result, mul_done_sig,
        input  gnt, busy, mul_A, mul_B, mul_start,
               resp_valid, resp_id, resp_result, resp_flags
    );
endinterface

// File: rtl/fmul_share_ctrl.sv
// rtl/fmul_share_ctrl.sv - round-robin sharing controller for one multi-cycle float multiplier
//
// Purpose: arbitrates NUM_REQ requesters onto a single start/done float
// multiplier, holds the operands and start level for the whole operation,
// and returns a tagged one-cycle response. Operands with a zero exponent
// (zero or denormal) never reach the multiplier because it forces the
// implicit leading 1; they are answered directly with a signed zero.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset
//   bus  fmul_share_ctrl_if.master: requests/operands in, grant out,
//        multiplier operands/start out, result/status in, response out

module fmul_share_ctrl #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    fmul_share_ctrl_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rrPtr;
    logic [ID_W-1:0] curId;
    logic [31:0]     mulA;
    logic [31:0]     mulB;
    logic            respValid;
    logic [ID_W-1:0] respId;
    logic [31:0]     respResult;
    logic [2:0]      respFlags;

    logic            found;
    logic [ID_W-1:0] pick;
    logic [31:0]     selA;
    logic [31:0]     selB;
    logic            bypass;

    // First requesting slot strictly after the last granted one, wrapping
    // around, so the last winner has lowest priority next time.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!found && bus.req[(int'(rrPtr) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(rrPtr) + i) % NUM_REQ);
            end
        end
    end

    assign selA   = bus.a_bus[32*int'(pick) +: 32];
    assign selB   = bus.b_bus[32*int'(pick) +: 32];
    assign bypass = (selA[30:23] == 8'd0) || (selB[30:23] == 8'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rrPtr      <= ID_W'(NUM_REQ - 1);
            curId      <= '0;
            mulA       <= '0;
            mulB       <= '0;
            respValid  <= 1'b0;
            respId     <= '0;
            respResult <= '0;
            respFlags  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    respValid <= 1'b0;
                    if (found) begin
                        rrPtr <= pick;
                        curId <= pick;
                        mulA  <= selA;
                        mulB  <= selB;
                        if (bypass) begin
                            // Product of a zero/denormal is a zero carrying the product sign.
                            respValid  <= 1'b1;
                            respId     <= pick;
                            respResult <= {selA[31] ^ selB[31], 31'd0};
                            respFlags  <= 3'b001;
                            state      <= RESP;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.mul_done_sig[0]) begin
                        respValid  <= 1'b1;
                        respId     <= curId;
                        respResult <= bus.mul_result;
                        respFlags  <= bus.mul_done_sig[3:1];
                        state      <= RESP;
                    end
                end
                RESP: begin
                    respValid <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    respValid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Grant is combinational so operands are sampled in the grant cycle;
    // it is gated by rst so every output is low while reset is asserted.
    assign bus.gnt         = (state == IDLE && found && !rst) ? (NUM_REQ'(1) << pick) : '0;
    assign bus.busy        = (state != IDLE);
    // Start stays high through the capture cycle so the multiplier's last
    // step clears its own counter.
    assign bus.mul_start   = (state == RUN);
    assign bus.mul_A       = mulA;
    assign bus.mul_B       = mulB;
    assign bus.resp_valid  = respValid;
    assign bus.resp_id     = respId;
    assign bus.resp_result = respResult;
    assign bus.resp_flags  = respFlags;

endmodule
